// File: rtl/conv_win_pkg.sv
// Shared types and helpers for the KxK window fetcher.
// Zero padding is compiled in when CONV_PAD_EN is defined.
package conv_win_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Up to 7x7 = 49 taps.
    localparam int TAP_W   = 6;
    localparam int KIDX_W  = 3;
    localparam int COORD_W = 16;

    typedef logic [TAP_W-1:0]         tap_idx_t;
    typedef logic [KIDX_W-1:0]        kidx_t;
    // Input-space coordinates; negative only for padded border windows.
    typedef logic signed [COORD_W:0]  scoord_t;

`ifdef CONV_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    function automatic int pad_amt(input int k);
        return PAD_EN ? k / 2 : 0;
    endfunction

    // Windows along one dimension.
    function automatic int grid_size(input int img, input int k, input int stride, input bit pad);
        if (pad)
            return (img + stride - 1) / stride;
        return (img - k) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Tap address generator: row-base accumulator plus column offset, with
// bounds test for padded builds (CONV_PAD_EN); no multiplier on the tap path.
module conv_tap_addr_gen
    import conv_win_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_scan_start,
    input  logic              i_tap_adv,
    input  logic              i_win_adv,
    input  logic              i_row_adv,
    input  scoord_t           i_org_row,
    input  scoord_t           i_org_col,
    input  kidx_t             i_tap_i,
    input  kidx_t             i_tap_j,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_in_bounds
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] WIN_STEP = ADDR_W'(STRIDE * IMG_W);
    // Modulo-2^ADDR_W start base; negative for a padded top border.
    localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(0) - ADDR_W'(pad_amt(K) * IMG_W);

    logic [ADDR_W-1:0] r_org_base;
    logic [ADDR_W-1:0] r_row_base;
    scoord_t           w_col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_org_base <= '0;
            r_row_base <= '0;
        end else if (i_scan_start) begin
            r_org_base <= BASE0;
            r_row_base <= BASE0;
        end else if (i_win_adv) begin
            if (i_row_adv) begin
                r_org_base <= r_org_base + WIN_STEP;
                r_row_base <= r_org_base + WIN_STEP;
            end else begin
                r_row_base <= r_org_base;
            end
        end else if (i_tap_adv && i_tap_j == kidx_t'(K - 1)) begin
            r_row_base <= r_row_base + ROW_STEP;
        end
    end

    assign w_col = i_org_col + scoord_t'(i_tap_j);

`ifdef CONV_PAD_EN
    scoord_t w_row;
    assign w_row       = i_org_row + scoord_t'(i_tap_i);
    assign o_in_bounds = (w_row >= 0) && (w_row < scoord_t'(IMG_H)) &&
                         (w_col >= 0) && (w_col < scoord_t'(IMG_W));
`else
    logic w_unused;
    assign w_unused    = ^{i_org_row, i_tap_i, 16'(IMG_H)};
    assign o_in_bounds = 1'b1;
`endif

    assign o_mem_addr = o_in_bounds ? r_row_base + ADDR_W'(w_col) : '0;

endmodule

// File: rtl/conv_window_fetch.sv
// KxK window fetcher: reads K*K taps per window from a synchronous-read pixel
// memory and presents the packed window over valid/ready. CONV_PAD_EN adds zero padding.
module conv_window_fetch
    import conv_win_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 640,
    parameter int PIX_W  = 8,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_re,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [K*K*PIX_W-1:0] win_data,
    output logic [15:0]          win_row,
    output logic [15:0]          win_col
);

    localparam int       KK       = K * K;
    localparam int       ROWS     = grid_size(IMG_H, K, STRIDE, PAD_EN);
    localparam int       COLS     = grid_size(IMG_W, K, STRIDE, PAD_EN);
    localparam tap_idx_t TAP_LAST = tap_idx_t'(KK - 1);
    localparam kidx_t    J_LAST   = kidx_t'(K - 1);
    localparam scoord_t  ORG0     = scoord_t'(-pad_amt(K));
    localparam scoord_t  ORG_STEP = scoord_t'(STRIDE);

    state_t   r_state;
    tap_idx_t r_tap;
    kidx_t    r_tap_i;
    kidx_t    r_tap_j;
    logic [15:0] r_win_row;
    logic [15:0] r_win_col;
    scoord_t  r_org_row;
    scoord_t  r_org_col;
    logic     r_cap_pend;
    tap_idx_t r_cap_slot;
    logic     r_cap_zero;

    logic w_in_bounds;
    logic w_last_col;
    logic w_last_win;
    logic w_scan_start;
    logic w_tap_adv;
    logic w_win_adv;

    assign w_last_col   = (r_win_col == 16'(COLS - 1));
    assign w_last_win   = w_last_col && (r_win_row == 16'(ROWS - 1));
    assign w_scan_start = (r_state == ST_IDLE) && start;
    assign w_tap_adv    = (r_state == ST_FETCH) && (r_tap != TAP_LAST);
    assign w_win_adv    = (r_state == ST_HOLD) && win_ready && !w_last_win;

    conv_tap_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .STRIDE(STRIDE),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_scan_start(w_scan_start),
        .i_tap_adv   (w_tap_adv),
        .i_win_adv   (w_win_adv),
        .i_row_adv   (w_last_col),
        .i_org_row   (r_org_row),
        .i_org_col   (r_org_col),
        .i_tap_i     (r_tap_i),
        .i_tap_j     (r_tap_j),
        .o_mem_addr  (mem_addr),
        .o_in_bounds (w_in_bounds)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tap      <= '0;
            r_tap_i    <= '0;
            r_tap_j    <= '0;
            r_win_row  <= '0;
            r_win_col  <= '0;
            r_org_row  <= '0;
            r_org_col  <= '0;
            r_cap_pend <= 1'b0;
            r_cap_slot <= '0;
            r_cap_zero <= 1'b0;
        end else begin
            r_cap_pend <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_FETCH;
                        r_tap     <= '0;
                        r_tap_i   <= '0;
                        r_tap_j   <= '0;
                        r_win_row <= '0;
                        r_win_col <= '0;
                        r_org_row <= ORG0;
                        r_org_col <= ORG0;
                    end
                end
                ST_FETCH: begin
                    // Read data returns next cycle; remember where it lands.
                    r_cap_pend <= 1'b1;
                    r_cap_slot <= r_tap;
                    r_cap_zero <= ~w_in_bounds;
                    if (r_tap == TAP_LAST) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_tap <= r_tap + tap_idx_t'(1);
                        if (r_tap_j == J_LAST) begin
                            r_tap_j <= '0;
                            r_tap_i <= r_tap_i + kidx_t'(1);
                        end else begin
                            r_tap_j <= r_tap_j + kidx_t'(1);
                        end
                    end
                end
                ST_DRAIN: r_state <= ST_HOLD;
                ST_HOLD: begin
                    if (win_ready) begin
                        if (w_last_win) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_FETCH;
                            r_tap   <= '0;
                            r_tap_i <= '0;
                            r_tap_j <= '0;
                            if (w_last_col) begin
                                r_win_col <= '0;
                                r_org_col <= ORG0;
                                r_win_row <= r_win_row + 16'd1;
                                r_org_row <= r_org_row + ORG_STEP;
                            end else begin
                                r_win_col <= r_win_col + 16'd1;
                                r_org_col <= r_org_col + ORG_STEP;
                            end
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < KK; gi++) begin : g_slot
        logic [PIX_W-1:0] r_slot;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_slot <= '0;
            else if (r_cap_pend && r_cap_slot == tap_idx_t'(gi))
                r_slot <= r_cap_zero ? '0 : mem_rdata;
        end
        assign win_data[gi*PIX_W +: PIX_W] = r_slot;
    end

    assign busy      = (r_state == ST_FETCH) || (r_state == ST_DRAIN) || (r_state == ST_HOLD);
    assign done      = (r_state == ST_DONE);
    assign win_valid = (r_state == ST_HOLD);
    assign mem_re    = (r_state == ST_FETCH) && w_in_bounds;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: 4x4/stride-1 and 5x5/stride-2 instances checked
// every cycle against a window-list model; follows CONV_PAD_EN when defined.
module tb_conv_window_fetch;

    localparam int K      = 3;
    localparam int KK     = K * K;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 19;
`ifdef CONV_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int P = PAD ? K / 2 : 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_fin  = 0;

    task automatic chk(input string name, input int cfg, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d t=%0t got %0h want %0h", name, cfg, $time, act, exp);
        end
    endtask

    // Windows per dimension for a square image of side w.
    function automatic int grid(input int w, input int s);
        return PAD ? (w + s - 1) / s : (w - K) / s + 1;
    endfunction

    function automatic int tap_y(input int w, input int s, input int idx, input int t);
        return (idx / grid(w, s)) * s - P + t / K;
    endfunction

    function automatic int tap_x(input int w, input int s, input int idx, input int t);
        return (idx % grid(w, s)) * s - P + t % K;
    endfunction

    function automatic bit tap_inb(input int w, input int s, input int idx, input int t);
        int y = tap_y(w, s, idx, t);
        int x = tap_x(w, s, idx, t);
        return (y >= 0) && (y < w) && (x >= 0) && (x < w);
    endfunction

    function automatic int tap_addr(input int w, input int s, input int idx, input int t);
        return tap_y(w, s, idx, t) * w + tap_x(w, s, idx, t);
    endfunction

    // Memory word = address + 1; outside taps read as 0.
    function automatic logic [KK*PIX_W-1:0] exp_win(input int w, input int s, input int idx);
        logic [KK*PIX_W-1:0] d = '0;
        for (int t = 0; t < KK; t++)
            if (tap_inb(w, s, idx, t))
                d[t*PIX_W +: PIX_W] = PIX_W'(tap_addr(w, s, idx, t) + 1);
        return d;
    endfunction

    // Hand-computed first windows pin the model.
    function automatic logic [KK*PIX_W-1:0] first_lit(input int cfg);
        int v[KK];
        logic [KK*PIX_W-1:0] d;
        if (!PAD && cfg == 0)      v = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        else if (!PAD)             v = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        else if (cfg == 0)         v = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        else                       v = '{0, 0, 0, 0, 1, 2, 0, 6, 7};
        for (int t = 0; t < KK; t++) d[t*PIX_W +: PIX_W] = PIX_W'(v[t]);
        return d;
    endfunction

    // Window (1,1): grid index and expected tap 0.
    function automatic int pin_idx(input int cfg);
        if (!PAD) return 3;
        return (cfg == 0) ? 5 : 4;
    endfunction

    function automatic int pin_val(input int cfg);
        if (!PAD) return (cfg == 0) ? 6 : 13;
        return (cfg == 0) ? 1 : 7;
    endfunction

    function automatic int nwin_lit(input int cfg);
        if (!PAD) return 4;
        return (cfg == 0) ? 16 : 9;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int W    = (gi == 0) ? 4 : 5;
        localparam int S    = (gi == 0) ? 1 : 2;
        localparam int NWIN = grid(W, S) * grid(W, S);

        logic                 rst = 1'b1;
        logic                 start = 1'b0;
        logic                 win_ready = 1'b0;
        logic                 busy, done, mem_re, win_valid;
        logic [ADDR_W-1:0]    mem_addr;
        logic [PIX_W-1:0]     mem_rdata;
        logic [KK*PIX_W-1:0]  win_data;
        logic [15:0]          win_row, win_col;

        conv_window_fetch #(
            .IMG_W (W),
            .IMG_H (W),
            .PIX_W (PIX_W),
            .K     (K),
            .STRIDE(S),
            .ADDR_W(ADDR_W)
        ) dut (
            .clk      (clk),
            .reset    (rst),
            .start    (start),
            .busy     (busy),
            .done     (done),
            .mem_re   (mem_re),
            .mem_addr (mem_addr),
            .mem_rdata(mem_rdata),
            .win_valid(win_valid),
            .win_ready(win_ready),
            .win_data (win_data),
            .win_row  (win_row),
            .win_col  (win_col)
        );

        // Synchronous-read memory; garbage when not read so stray captures show.
        always @(posedge clk)
            mem_rdata <= mem_re ? PIX_W'(mem_addr + 1) : PIX_W'($urandom);

        // Model phase: -1 idle, -2 done, 0..KK-1 tap, KK drain, KK+1 hold.
        int m_phase = -1;
        int m_win   = 0;
        int n_acc   = 0;
        int n_done  = 0;

        initial forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", gi, busy, 0);
                chk("rst_done", gi, done, 0);
                chk("rst_mem_re", gi, mem_re, 0);
                chk("rst_mem_addr", gi, mem_addr, 0);
                chk("rst_win_valid", gi, win_valid, 0);
                chk("rst_win_data", gi, win_data, 0);
                chk("rst_win_row", gi, win_row, 0);
                chk("rst_win_col", gi, win_col, 0);
                m_phase = -1;
                m_win   = 0;
                n_acc   = 0;
            end else begin
                if (m_phase == -1) begin
                    chk("idle_busy", gi, busy, 0);
                    chk("idle_done", gi, done, 0);
                    chk("idle_mem_re", gi, mem_re, 0);
                    chk("idle_win_valid", gi, win_valid, 0);
                end else if (m_phase == -2) begin
                    chk("done_pulse", gi, done, 1);
                    chk("done_mem_re", gi, mem_re, 0);
                    chk("done_win_valid", gi, win_valid, 0);
                    chk("win_count", gi, n_acc, nwin_lit(gi));
                end else if (m_phase < KK) begin
                    chk("fetch_busy", gi, busy, 1);
                    chk("fetch_win_valid", gi, win_valid, 0);
                    chk("fetch_done", gi, done, 0);
                    chk("fetch_mem_re", gi, mem_re, tap_inb(W, S, m_win, m_phase));
                    if (tap_inb(W, S, m_win, m_phase))
                        chk("fetch_mem_addr", gi, mem_addr, tap_addr(W, S, m_win, m_phase));
                end else if (m_phase == KK) begin
                    chk("drain_busy", gi, busy, 1);
                    chk("drain_win_valid", gi, win_valid, 0);
                    chk("drain_mem_re", gi, mem_re, 0);
                end else begin
                    chk("hold_win_valid", gi, win_valid, 1);
                    chk("hold_mem_re", gi, mem_re, 0);
                    chk("hold_busy", gi, busy, 1);
                    chk("win_row", gi, win_row, m_win / grid(W, S));
                    chk("win_col", gi, win_col, m_win % grid(W, S));
                    chk("win_data", gi, win_data, exp_win(W, S, m_win));
                    if (m_win == 0)
                        chk("first_win_lit", gi, win_data, first_lit(gi));
                    if (m_win == pin_idx(gi))
                        chk("win11_tap0_lit", gi, win_data[PIX_W-1:0], pin_val(gi));
                end

                if (m_phase == -1) begin
                    if (start) begin
                        m_phase = 0;
                        m_win   = 0;
                        n_acc   = 0;
                    end
                end else if (m_phase == -2) begin
                    m_phase = -1;
                    n_done++;
                end else if (m_phase == KK + 1) begin
                    if (win_ready) begin
                        n_acc++;
                        if (m_win == NWIN - 1) begin
                            m_phase = -2;
                        end else begin
                            m_win++;
                            m_phase = 0;
                        end
                    end
                end else begin
                    m_phase++;
                end
            end
        end

        initial begin
            int cnt;
            repeat (3) @(posedge clk);
            #2 rst = 1'b0;
            repeat (2) @(posedge clk);

            // Scan 1: ready always high, latency to first window.
            #2 win_ready = 1'b1;
            start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!win_valid && cnt < 100);
            chk("first_valid_latency", gi, cnt, KK + 2);
            for (int t = 0; t < 2000; t++) begin
                @(negedge clk);
                if (done) break;
            end
            chk("scan1_done", gi, done, 1);
            repeat (3) @(posedge clk);

            // Scan 2: stall first window, then random ready with start noise.
            #2 win_ready = 1'b0;
            start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (win_valid) break;
            end
            chk("stall_valid", gi, win_valid, 1);
            repeat (5) begin
                @(negedge clk);
                chk("stall_mem_re", gi, mem_re, 0);
            end
            @(posedge clk);
            #2 win_ready = 1'b1;
            @(posedge clk);
            #2 win_ready = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                win_ready = ($urandom_range(0, 2) != 0);
                start     = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                if (done) break;
                @(posedge clk);
                #2;
            end
            chk("scan2_done", gi, done, 1);
            @(posedge clk);
            #2 start = 1'b0;
            win_ready = 1'b1;
            repeat (2) @(posedge clk);

            // Scan 3: reset at tap 4 of window 2.
            #2 start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
            for (int t = 0; t < 500; t++) begin
                @(posedge clk);
                #2;
                if (m_win == 2 && m_phase == 4) break;
            end
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #2 rst = 1'b0;
            repeat (2) @(posedge clk);

            // Scan 4: restart after reset with random ready.
            #2 start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                win_ready = ($urandom_range(0, 1) != 0);
                @(negedge clk);
                if (done) break;
                @(posedge clk);
                #2;
            end
            chk("scan4_done", gi, done, 1);
            repeat (3) @(posedge clk);
            chk("done_total", gi, n_done, 3);
            n_fin++;
        end
    end

    initial begin
        for (int t = 0; t < 50000 && n_fin < 2; t++) @(posedge clk);
        if (n_fin < 2) begin
            checks++;
            errors++;
            $display("FAIL watchdog: finished %0d of 2 configs", n_fin);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
